// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID/EX pipeline sequencer: controller state
// encoding and the NOP/bubble encodings used by if_id_reg and id_ex_reg.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctrl_state_e;

    // addi x0,x0,0 loaded into if_id_reg on flush; id_ex_reg bubbles clear reg_we
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic        BUBBLE_REGWE = 1'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, hold/flush controls and debug out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic [4:0]       ex_rd_i;
    logic             ex_reg_we_i;
    logic             ex_is_load_i;
    logic             ex_mdu_start_i;
    logic             mdu_done_i;
    logic             ex_branch_taken_i;
    logic             mem_busy_i;
    logic             stall_cnt_clr_i;
    logic             pc_hold_o;
    logic             if_id_hold_o;
    logic             if_id_flush_o;
    logic             id_ex_hold_o;
    logic             id_ex_flush_o;
    logic             ex_mem_hold_o;
    logic [1:0]       ctrl_state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             mdu_timeout_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_reg_we_i, ex_is_load_i, ex_mdu_start_i, mdu_done_i,
               ex_branch_taken_i, mem_busy_i, stall_cnt_clr_i,
        input  pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o,
               id_ex_flush_o, ex_mem_hold_o, ctrl_state_o, stall_cnt_o,
               mdu_timeout_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_reg_we_i, ex_is_load_i, ex_mdu_start_i, mdu_done_i,
               ex_branch_taken_i, mem_busy_i, stall_cnt_clr_i,
        output pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o,
               id_ex_flush_o, ex_mem_hold_o, ctrl_state_o, stall_cnt_o,
               mdu_timeout_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID source registers and the EX load.
module hazard_detect (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_reg_we_i,
    input  logic       ex_is_load_i,
    output logic       ld_hit_o
);
    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_match = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    // x0 never carries a real dependency
    assign ld_hit_o  = ex_is_load_i && ex_reg_we_i && (ex_rd_i != 5'd0) &&
                       (rs1_match || rs2_match);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID/EX sequencer: load-use bubbles, MDU and data-memory holds, branch squash,
// MDU watchdog and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 32,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int               TMR_W   = $clog2(MDU_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MDU_TIMEOUT - 1);

    ctrl_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             ld_hit;
    logic             pc_hold, if_id_hold, if_id_flush;
    logic             id_ex_hold, id_ex_flush, ex_mem_hold, mdu_timeout;
    logic             timer_at_max;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (bus.id_rs1_i),
        .id_rs2_i      (bus.id_rs2_i),
        .id_rs1_used_i (bus.id_rs1_used_i),
        .id_rs2_used_i (bus.id_rs2_used_i),
        .ex_rd_i       (bus.ex_rd_i),
        .ex_reg_we_i   (bus.ex_reg_we_i),
        .ex_is_load_i  (bus.ex_is_load_i),
        .ld_hit_o      (ld_hit)
    );

    assign timer_at_max = (timer_q == TMR_MAX);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_hold  = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        mdu_timeout = 1'b0;
        // Outputs stay quiet for the whole reset assertion, not only after the edge
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mem_busy_i) begin
                        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
                        state_d = ST_MEM_WAIT;
                    end else if (bus.ex_branch_taken_i) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.ex_mdu_start_i) begin
                        {pc_hold, if_id_hold, id_ex_hold} = 3'b111;
                        timer_d = '0;
                        state_d = ST_MDU_WAIT;
                    end else if (ld_hit) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    timer_d = timer_at_max ? timer_q : timer_q + TMR_W'(1);
                    // A busy memory defers the MDU exit; done has priority over expiry
                    if (bus.mem_busy_i) begin
                        {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
                    end else if (bus.mdu_done_i) begin
                        state_d = ST_RUN;
                    end else if (timer_at_max) begin
                        mdu_timeout = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        {pc_hold, if_id_hold, id_ex_hold} = 3'b111;
                    end
                end
                ST_MEM_WAIT: begin
                    {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = {4{bus.mem_busy_i}};
                    if (!bus.mem_busy_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.stall_cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_hold_o     = pc_hold;
    assign bus.if_id_hold_o  = if_id_hold;
    assign bus.if_id_flush_o = if_id_flush;
    assign bus.id_ex_hold_o  = id_ex_hold;
    assign bus.id_ex_flush_o = id_ex_flush;
    assign bus.ex_mem_hold_o = ex_mem_hold;
    assign bus.ctrl_state_o  = state_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.mdu_timeout_o = mdu_timeout;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MDU_TIMEOUT=8, 6-bit counter).
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TO    = 8;
    localparam int CNT_W = 6;
    // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold}
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] H3 = 6'b110100;
    localparam logic [5:0] H4 = 6'b110101;
    localparam logic [5:0] FL = 6'b001010;
    localparam logic [5:0] LD = 6'b110010;

    typedef struct {
        string      name;
        logic [5:0] hf;
        logic [1:0] st;
        int         cnt;
        logic       to;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // Monitor: every cycle the controller presents a decision; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] hf;
            e  = exp_q.pop_front();
            hf = {bus.pc_hold_o, bus.if_id_hold_o, bus.if_id_flush_o,
                  bus.id_ex_hold_o, bus.id_ex_flush_o, bus.ex_mem_hold_o};
            n_checks = n_checks + 4;
            if (hf !== e.hf) begin
                n_errors++;
                $display("FAIL %s holds/flushes got=%b want=%b", e.name, hf, e.hf);
            end
            if (bus.ctrl_state_o !== e.st) begin
                n_errors++;
                $display("FAIL %s state got=%0d want=%0d", e.name, bus.ctrl_state_o, e.st);
            end
            if (int'(bus.stall_cnt_o) != e.cnt || $isunknown(bus.stall_cnt_o)) begin
                n_errors++;
                $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt_o, e.cnt);
            end
            if (bus.mdu_timeout_o !== e.to) begin
                n_errors++;
                $display("FAIL %s timeout got=%b want=%b", e.name, bus.mdu_timeout_o, e.to);
            end
        end
    end

    task automatic idle();
        bus.id_rs1_i          = 5'd0;
        bus.id_rs2_i          = 5'd0;
        bus.id_rs1_used_i     = 1'b0;
        bus.id_rs2_used_i     = 1'b0;
        bus.ex_rd_i           = 5'd0;
        bus.ex_reg_we_i       = 1'b0;
        bus.ex_is_load_i      = 1'b0;
        bus.ex_mdu_start_i    = 1'b0;
        bus.mdu_done_i        = 1'b0;
        bus.ex_branch_taken_i = 1'b0;
        bus.mem_busy_i        = 1'b0;
        bus.stall_cnt_clr_i   = 1'b0;
    endtask

    task automatic set_ld(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we,
                          input logic ld);
        bus.id_rs1_i      = rs1;
        bus.id_rs1_used_i = u1;
        bus.id_rs2_i      = rs2;
        bus.id_rs2_used_i = u2;
        bus.ex_rd_i       = rd;
        bus.ex_reg_we_i   = we;
        bus.ex_is_load_i  = ld;
    endtask

    task automatic step(input string name, input logic [5:0] hf, input logic [1:0] st,
                        input int cnt, input logic to);
        exp_t e;
        e.name = name; e.hf = hf; e.st = st; e.cnt = cnt; e.to = to;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("NOP encoding %h, bubble reg_we %b", NOP_INSTR, BUBBLE_REGWE);
        idle();
        rst = 1'b1;
        bus.mem_busy_i     = 1'b1;
        bus.ex_mdu_start_i = 1'b1;
        step("reset", Z, 2'd0, 0, 1'b0);
        rst = 1'b0;
        idle();
        step("idle", Z, 2'd0, 0, 1'b0);

        // Load-use: ld x5 in EX, add x6,x5,x1 in ID
        set_ld(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1);
        step("ldhit_rs1", LD, 2'd0, 0, 1'b0);
        idle();
        step("ldhit_after", Z, 2'd0, 1, 1'b0);
        set_ld(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        step("ld_x0", Z, 2'd0, 1, 1'b0);
        set_ld(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
        step("ldhit_rs2", LD, 2'd0, 1, 1'b0);
        set_ld(5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
        step("ld_rs_unused", Z, 2'd0, 2, 1'b0);
        set_ld(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
        step("not_load", Z, 2'd0, 2, 1'b0);
        idle();
        bus.stall_cnt_clr_i = 1'b1;
        step("clr", Z, 2'd0, 2, 1'b0);
        idle();

        // MDU op with done four cycles after start; start/branch ignored while waiting
        bus.ex_mdu_start_i = 1'b1;
        step("mdu_start", H3, 2'd0, 0, 1'b0);
        step("mdu_w1", H3, 2'd1, 1, 1'b0);
        bus.ex_mdu_start_i = 1'b0;
        bus.ex_branch_taken_i = 1'b1;
        step("mdu_w2_branch", H3, 2'd1, 2, 1'b0);
        bus.ex_branch_taken_i = 1'b0;
        step("mdu_w3", H3, 2'd1, 3, 1'b0);
        bus.mdu_done_i = 1'b1;
        step("mdu_done", Z, 2'd1, 4, 1'b0);
        idle();
        step("mdu_back_run", Z, 2'd0, 4, 1'b0);

        // Watchdog expiry on the 8th wait cycle
        bus.ex_mdu_start_i = 1'b1;
        step("to_start", H3, 2'd0, 4, 1'b0);
        bus.ex_mdu_start_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) step("to_wait", H3, 2'd1, 5 + i, 1'b0);
        step("to_expire", Z, 2'd1, 12, 1'b1);
        step("to_back_run", Z, 2'd0, 12, 1'b0);

        // Done coinciding with expiry: no pulse
        bus.ex_mdu_start_i = 1'b1;
        step("co_start", H3, 2'd0, 12, 1'b0);
        bus.ex_mdu_start_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) step("co_wait", H3, 2'd1, 13 + i, 1'b0);
        bus.mdu_done_i = 1'b1;
        step("co_done", Z, 2'd1, 20, 1'b0);
        idle();
        step("co_back_run", Z, 2'd0, 20, 1'b0);

        // Memory busy during MDU wait defers done
        bus.ex_mdu_start_i = 1'b1;
        step("mb_start", H3, 2'd0, 20, 1'b0);
        bus.ex_mdu_start_i = 1'b0;
        bus.mem_busy_i = 1'b1;
        bus.mdu_done_i = 1'b1;
        step("mb_busy_done", H4, 2'd1, 21, 1'b0);
        bus.mem_busy_i = 1'b0;
        step("mb_done", Z, 2'd1, 22, 1'b0);
        idle();
        step("mb_back_run", Z, 2'd0, 22, 1'b0);

        // Timer saturates while memory is busy, then expires on release
        bus.ex_mdu_start_i = 1'b1;
        step("sat_start", H3, 2'd0, 22, 1'b0);
        bus.ex_mdu_start_i = 1'b0;
        bus.mem_busy_i = 1'b1;
        for (int i = 0; i < 9; i++) step("sat_busy", H4, 2'd1, 23 + i, 1'b0);
        bus.mem_busy_i = 1'b0;
        step("sat_expire", Z, 2'd1, 32, 1'b1);
        step("sat_back_run", Z, 2'd0, 32, 1'b0);

        // Branch together with load-use: flush wins, no holds
        set_ld(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1);
        bus.ex_branch_taken_i = 1'b1;
        step("br_ldhit", FL, 2'd0, 32, 1'b0);
        idle();
        bus.ex_branch_taken_i = 1'b1;
        bus.ex_mdu_start_i = 1'b1;
        step("br_over_mdu", FL, 2'd0, 32, 1'b0);
        idle();
        step("br_after", Z, 2'd0, 32, 1'b0);

        // Memory busy for 3 cycles, branch pending until after release
        bus.mem_busy_i = 1'b1;
        step("mem_b1", H4, 2'd0, 32, 1'b0);
        bus.ex_branch_taken_i = 1'b1;
        step("mem_b2", H4, 2'd2, 33, 1'b0);
        step("mem_b3", H4, 2'd2, 34, 1'b0);
        bus.mem_busy_i = 1'b0;
        step("mem_release", Z, 2'd2, 35, 1'b0);
        step("mem_branch", FL, 2'd0, 35, 1'b0);
        idle();
        step("mem_after", Z, 2'd0, 35, 1'b0);

        // Reset in the middle of an MDU wait
        bus.ex_mdu_start_i = 1'b1;
        step("rs_start", H3, 2'd0, 35, 1'b0);
        bus.ex_mdu_start_i = 1'b0;
        step("rs_wait", H3, 2'd1, 36, 1'b0);
        rst = 1'b1;
        step("rs_reset", Z, 2'd0, 0, 1'b0);
        rst = 1'b0;
        step("rs_after", Z, 2'd0, 0, 1'b0);

        // Clear wins over increment
        set_ld(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        step("clr_pre", LD, 2'd0, 0, 1'b0);
        bus.stall_cnt_clr_i = 1'b1;
        step("clr_vs_inc", LD, 2'd0, 1, 1'b0);
        idle();
        step("clr_result", Z, 2'd0, 0, 1'b0);

        // Counter saturation at all-ones
        bus.mem_busy_i = 1'b1;
        for (int i = 0; i < 67; i++)
            step("sat_cnt", H4, (i == 0) ? 2'd0 : 2'd2, (i < 63) ? i : 63, 1'b0);
        bus.mem_busy_i = 1'b0;
        step("sat_cnt_release", Z, 2'd2, 63, 1'b0);
        bus.stall_cnt_clr_i = 1'b1;
        step("sat_cnt_clr", Z, 2'd0, 63, 1'b0);
        idle();
        step("sat_cnt_zero", Z, 2'd0, 0, 1'b0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
